// File: rtl/fetch_stage.sv
// fetch_stage: holds the PC, drives instruction memory, and registers the
// fetched word into the IF/ID pipeline register. The 6-bit opcode is taken
// from the registered word and goes to the main decoder.
// Stall, flush and branch/jump redirects come from later stages.
module fetch_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               jump,
  input  logic [PC_W-1:0]    jump_target,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic [5:0]         opcode
);

  // Mask that clears the two byte-offset bits of a target address.
  localparam logic [PC_W-1:0] WORD_MASK = ~(PC_W'(3));
  localparam logic [PC_W-1:0] PC_INCR   = PC_W'(4);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc4_q, pc4_d;
  logic               valid_q, valid_d;

  logic               redirect;
  logic [PC_W-1:0]    target_raw;
  logic [PC_W-1:0]    target;
  logic [PC_W-1:0]    pc_plus4;

  // Redirect selection: a taken branch wins over a simultaneous jump, and the
  // chosen target is forced word-aligned.
  always_comb begin
    redirect   = branch_taken | jump;
    target_raw = branch_taken ? branch_target : jump_target;
    target     = target_raw & WORD_MASK;
    pc_plus4   = pc_q + PC_INCR;  // wraps modulo 2^PC_W
  end

  // PC next state: redirect overrides stall; otherwise advance one word.
  always_comb begin
    pc_d = pc_plus4;
    if (redirect) begin
      pc_d = target;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // IF/ID next state: a redirect also squashes the word fetched on the wrong
  // path, so it bubbles the register exactly like a flush.
  always_comb begin
    instr_d = imem_rdata;
    pc4_d   = pc_plus4;
    valid_d = 1'b1;
    if (flush || redirect) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end
  end

  // PC register; reset returns it to RESET_PC independent of the clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID pipeline register; reset leaves an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  // Outputs: only imem_addr is combinational, and only from the PC register;
  // everything else is taken straight from IF/ID state.
  always_comb begin
    imem_addr   = pc_q;
    if_id_instr = instr_q;
    if_id_pc4   = pc4_q;
    if_id_valid = valid_q;
    opcode      = instr_q[INSTR_W-1 -: 6];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns word == address.
// A second instance with RESET_PC at the top of the address space covers PC wrap
// and a non-zero opcode.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  opcode;

  logic        z_stall, z_flush, z_br, z_jmp;
  logic [31:0] z_btgt, z_jtgt;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc4;
  logic        w_valid;
  logic [5:0]  w_opcode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr;
  assign w_rdata    = w_addr;

  fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .opcode(opcode)
  );

  fetch_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .stall(z_stall), .flush(z_flush),
    .branch_taken(z_br), .branch_target(z_btgt),
    .jump(z_jmp), .jump_target(z_jtgt),
    .imem_addr(w_addr), .imem_rdata(w_rdata),
    .if_id_instr(w_instr), .if_id_pc4(w_pc4),
    .if_id_valid(w_valid), .opcode(w_opcode)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid,
                            input logic [31:0] addr);
    check_eq({tag, ".instr"}, if_id_instr, instr);
    check_eq({tag, ".pc4"},   if_id_pc4,   pc4);
    check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    check_eq({tag, ".addr"},  imem_addr,   addr);
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    z_stall = 1'b0; z_flush = 1'b0; z_br = 1'b0; z_jmp = 1'b0;
    z_btgt = '0; z_jtgt = '0;

    // Reset state
    tick(); tick();
    check_ifid("rst", 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("rst.opcode", {26'd0, opcode}, 32'h0);
    check_eq("wrap.rst.addr", w_addr, 32'hFFFF_FFFC);
    check_eq("wrap.rst.valid", {31'd0, w_valid}, 32'h0);

    // 1: reset release, sequential fetch
    reset = 1'b1;
    tick();
    check_ifid("seq1", 32'h0, 32'h4, 1'b1, 32'h4);
    check_eq("wrap.e1.pc4", w_pc4, 32'h0);
    check_eq("wrap.e1.instr", w_instr, 32'hFFFF_FFFC);
    check_eq("wrap.e1.opcode", {26'd0, w_opcode}, 32'h3F);
    check_eq("wrap.e1.addr", w_addr, 32'h0);
    tick();
    check_ifid("seq2", 32'h4, 32'h8, 1'b1, 32'h8);
    check_eq("wrap.e2.pc4", w_pc4, 32'h4);
    check_eq("wrap.e2.opcode", {26'd0, w_opcode}, 32'h0);

    // 2: stall two cycles at PC=8
    stall = 1'b1;
    tick();
    check_ifid("stall1", 32'h4, 32'h8, 1'b1, 32'h8);
    tick();
    check_ifid("stall2", 32'h4, 32'h8, 1'b1, 32'h8);
    stall = 1'b0;
    tick();
    check_ifid("resume", 32'h8, 32'hC, 1'b1, 32'hC);
    tick();
    check_ifid("seq5", 32'hC, 32'h10, 1'b1, 32'h10);

    // 3: branch at PC=0x10 to 0x40
    branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    check_ifid("br", 32'h0, 32'h0, 1'b0, 32'h40);
    branch_taken = 1'b0;
    tick();
    check_ifid("br.tgt", 32'h40, 32'h44, 1'b1, 32'h44);

    // 4: branch + jump + stall together; branch wins, redirect beats stall
    branch_taken = 1'b1; branch_target = 32'h80;
    jump = 1'b1; jump_target = 32'h200; stall = 1'b1;
    tick();
    check_ifid("brjmp", 32'h0, 32'h0, 1'b0, 32'h80);
    branch_taken = 1'b0; stall = 1'b0; jump_target = 32'h203;
    tick();
    check_ifid("jmp.align", 32'h0, 32'h0, 1'b0, 32'h200);
    jump = 1'b0;

    // flush alone: PC advances, IF/ID bubbles
    flush = 1'b1;
    tick();
    check_ifid("flush", 32'h0, 32'h0, 1'b0, 32'h204);
    // stall with flush: PC holds, IF/ID bubbles
    stall = 1'b1;
    tick();
    check_ifid("stallflush", 32'h0, 32'h0, 1'b0, 32'h204);
    stall = 1'b0; flush = 1'b0;
    tick();
    check_ifid("post.flush", 32'h204, 32'h208, 1'b1, 32'h208);

    // 6: async reset mid-cycle with a redirect pending
    #2;
    branch_taken = 1'b1; branch_target = 32'h300; stall = 1'b1; flush = 1'b1;
    reset = 1'b0;
    #1;
    check_ifid("async.rst", 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("async.rst.opcode", {26'd0, opcode}, 32'h0);
    tick();
    check_ifid("rst.held", 32'h0, 32'h0, 1'b0, 32'h0);
    branch_taken = 1'b0; stall = 1'b0; flush = 1'b0;
    reset = 1'b1;
    tick();
    check_ifid("rst.again", 32'h0, 32'h4, 1'b1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
